computation_sequencer: RTL
==========================

COMPUTATION_SEQUENCER -- requirements
Module: computation_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles an enable may stay high without its done before abort.
REQ-002 Parameter FEAT_STRIDE, default 4, systolic feature base increment per output element.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to run one computation.
REQ-006 run_mode  in  1  0 = serial run, 1 = systolic run.
REQ-007 ser_base  in  8  serial feature base address.
REQ-008 sys_base  in  6  systolic feature base address for the first element.
REQ-009 serial_mode_done / weight_Preloader_done / feature_Loader_done  in  1 each  completion flags from the computation module.
REQ-010 serial_mode_en / Weight_Preloader_en / Feature_Loader_en  out  1 each  level enables to the computation module.
REQ-011 systolic_mode  out  1  0 = weight preload, 1 = feature load.
REQ-012 c_reg_sel  out  2  result register select: 0=c11, 1=c12, 2=c21, 3=c22.
REQ-013 computation_mode_sel  out  1  0 = serial path owns memory port, 1 = systolic path.
REQ-014 serial_mode_feature_baseaddr  out  8; systolic_mode_feature_baseaddr  out  6; both registered.
REQ-015 busy  out  1; done  out  1 (one-cycle pulse); error  out  1 (sticky).

Function
REQ-016 States SHALL be IDLE, SER_RUN, WP_RUN, GAP, FL_RUN, FIN, ERR.
REQ-017 start SHALL be accepted only in IDLE, FIN or ERR; run_mode, ser_base, sys_base latched on acceptance; start in any other state ignored.
REQ-018 Accepting start SHALL clear error and enter SER_RUN (run_mode=0) or WP_RUN (run_mode=1); the enable is high in the first cycle after the start edge.
REQ-019 SER_RUN: serial_mode_en=1, computation_mode_sel=0, serial base driven; serial_mode_done=1 -> FIN, serial_mode_en low the next cycle.
REQ-020 WP_RUN: Weight_Preloader_en=1, systolic_mode=0, computation_mode_sel=1; weight_Preloader_done=1 -> GAP with element index k=0.
REQ-021 GAP: all enables low for exactly one cycle, then FL_RUN.
REQ-022 FL_RUN: Feature_Loader_en=1, systolic_mode=1, c_reg_sel=k, systolic base = sys_base + k*FEAT_STRIDE modulo 64.
REQ-023 feature_Loader_done=1 in FL_RUN: k<3 -> k+1, GAP; k=3 -> FIN.
REQ-024 A done input SHALL be honored only while its own enable is high; other done inputs are ignored.
REQ-025 FIN SHALL assert done for one cycle, then go to IDLE unless start is accepted in that cycle.
REQ-026 Watchdog: an 8-bit+ counter SHALL clear on every enable rise and increment while an enable is high; on reaching TIMEOUT, enables drop next cycle, state ERR, error=1.
REQ-027 ERR holds all enables low, error=1, busy=0, until start or reset.
REQ-028 busy=1 in SER_RUN, WP_RUN, GAP, FL_RUN; 0 otherwise.
REQ-029 computation_mode_sel SHALL hold its last value in IDLE/FIN/ERR so the memory mux does not glitch.

Reset
REQ-030 rst low SHALL asynchronously force IDLE, k=0, watchdog=0, all enables 0, systolic_mode=0, c_reg_sel=0, computation_mode_sel=0, base outputs 0, busy=0, done=0, error=0.
REQ-031 Reset mid-run SHALL abort with no done pulse; the first edge after release SHALL see IDLE.

Structure
REQ-032 State encodings, run_mode codes and c_reg_sel codes SHALL reside in the shared package as named constants.
REQ-033 The watchdog SHALL be a separate sub-module, sequencer_watchdog (clear, enable, limit in; expired out).

Verification
REQ-034 Serial: start, run_mode=0, ser_base=0x20, done after 10 cycles -> serial_mode_en high 10 cycles, base=0x20, sel=0, done pulse once.
REQ-035 Systolic: run_mode=1, sys_base=8, each done after 5 cycles -> WP once, then FL with c_reg_sel 0,1,2,3 and bases 8,12,16,20, one-cycle gaps, done once.
REQ-036 Wrap: sys_base=60, FEAT_STRIDE=4 -> bases 60,0,4,8.
REQ-037 Timeout: TIMEOUT=16, no feature_Loader_done -> enable drops after 16 cycles, error=1, no done; next start clears error.
REQ-038 Reset at k=2 mid FL_RUN -> all outputs at reset values immediately, no done; new start runs cleanly from WP_RUN.
REQ-039 Robustness: start while busy and stray serial_mode_done during systolic run -> both ignored, sequence unchanged.

Source files
------------

// File: rtl/computation_sequencer_pkg.sv
// rtl/computation_sequencer_pkg.sv - shared encodings for the computation sequencer
package computation_sequencer_pkg;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SER_RUN = 3'd1;
   localparam logic [2:0] S_WP_RUN  = 3'd2;
   localparam logic [2:0] S_GAP     = 3'd3;
   localparam logic [2:0] S_FL_RUN  = 3'd4;
   localparam logic [2:0] S_FIN     = 3'd5;
   localparam logic [2:0] S_ERR     = 3'd6;

   localparam logic RUN_SERIAL   = 1'b0;
   localparam logic RUN_SYSTOLIC = 1'b1;

   localparam logic [1:0] CREG_C11 = 2'd0;
   localparam logic [1:0] CREG_C12 = 2'd1;
   localparam logic [1:0] CREG_C21 = 2'd2;
   localparam logic [1:0] CREG_C22 = 2'd3;

   localparam logic MSEL_SERIAL   = 1'b0;
   localparam logic MSEL_SYSTOLIC = 1'b1;

   localparam int WDOG_W = 16;

   typedef logic [2:0] seq_state_t;

   function automatic logic accepts_start(input seq_state_t s);
      return (s == S_IDLE) || (s == S_FIN) || (s == S_ERR);
   endfunction

   function automatic logic is_busy_state(input seq_state_t s);
      return (s == S_SER_RUN) || (s == S_WP_RUN) || (s == S_GAP) || (s == S_FL_RUN);
   endfunction

endpackage

// File: rtl/sequencer_watchdog.sv
// rtl/sequencer_watchdog.sv - cycle counter that flags an enable held too long
module sequencer_watchdog #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] limit,
   output logic         expired
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 1'b1;
      end
   end

   // Fires during the limit-th enabled cycle so the enable is low on the next one.
   assign expired = enable && (({1'b0, count} + (W+1)'(1)) >= {1'b0, limit});

endmodule

// File: rtl/computation_sequencer.sv
// rtl/computation_sequencer.sv - sequences serial or systolic runs of the computation module
module computation_sequencer
   import computation_sequencer_pkg::*;
#(
   parameter int TIMEOUT     = 255,
   parameter int FEAT_STRIDE = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       run_mode,
   input  logic [7:0] ser_base,
   input  logic [5:0] sys_base,
   input  logic       serial_mode_done,
   input  logic       weight_Preloader_done,
   input  logic       feature_Loader_done,
   output logic       serial_mode_en,
   output logic       Weight_Preloader_en,
   output logic       Feature_Loader_en,
   output logic       systolic_mode,
   output logic [1:0] c_reg_sel,
   output logic       computation_mode_sel,
   output logic [7:0] serial_mode_feature_baseaddr,
   output logic [5:0] systolic_mode_feature_baseaddr,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam logic [WDOG_W-1:0] TIMEOUT_L = WDOG_W'(TIMEOUT);
   localparam logic [5:0]        STRIDE_L  = 6'(FEAT_STRIDE);

   seq_state_t state;
   seq_state_t state_next;
   logic [1:0] k;
   logic       accept;
   logic       any_en;
   logic       expired;

   assign accept = start && accepts_start(state);
   assign any_en = serial_mode_en || Weight_Preloader_en || Feature_Loader_en;

   // Holding the counter clear while no enable is high restarts it on every enable rise.
   sequencer_watchdog #(.W(WDOG_W)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (!any_en),
      .enable  (any_en),
      .limit   (TIMEOUT_L),
      .expired (expired)
   );

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE, S_FIN, S_ERR: begin
            if (accept) begin
               state_next = (run_mode == RUN_SERIAL) ? S_SER_RUN : S_WP_RUN;
            end else if (state == S_FIN) begin
               state_next = S_IDLE;
            end
         end
         S_SER_RUN: begin
            if (serial_mode_done)  state_next = S_FIN;
            else if (expired)      state_next = S_ERR;
         end
         S_WP_RUN: begin
            if (weight_Preloader_done) state_next = S_GAP;
            else if (expired)          state_next = S_ERR;
         end
         S_GAP: begin
            state_next = S_FL_RUN;
         end
         S_FL_RUN: begin
            if (feature_Loader_done) state_next = (k == CREG_C22) ? S_FIN : S_GAP;
            else if (expired)        state_next = S_ERR;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                          <= S_IDLE;
         k                              <= CREG_C11;
         computation_mode_sel           <= MSEL_SERIAL;
         serial_mode_feature_baseaddr   <= '0;
         systolic_mode_feature_baseaddr <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            k                              <= CREG_C11;
            computation_mode_sel           <= (run_mode == RUN_SYSTOLIC) ? MSEL_SYSTOLIC : MSEL_SERIAL;
            serial_mode_feature_baseaddr   <= ser_base;
            systolic_mode_feature_baseaddr <= sys_base;
         end else if ((state == S_FL_RUN) && feature_Loader_done && (k != CREG_C22)) begin
            // 6-bit add wraps the feature base modulo 64.
            k                              <= k + 2'd1;
            systolic_mode_feature_baseaddr <= systolic_mode_feature_baseaddr + STRIDE_L;
         end
      end
   end

   assign serial_mode_en      = (state == S_SER_RUN);
   assign Weight_Preloader_en = (state == S_WP_RUN);
   assign Feature_Loader_en   = (state == S_FL_RUN);
   assign systolic_mode       = (state == S_FL_RUN);
   assign c_reg_sel           = k;
   assign busy                = is_busy_state(state);
   assign done                = (state == S_FIN);
   assign error               = (state == S_ERR);

endmodule
